// File: rtl/fpu_result_bridge.sv
// Round-robin collector of FPU channel results into a FIFO drained over Wishbone,
// with a GPIO mirror of the latest (or head) result and a pending-data IRQ.
module fpu_result_bridge #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 8,
  parameter int          NUM_CH = 2,
  parameter logic [31:0] BASE   = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_CH-1:0]        res_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] res_data_i,
  output logic [NUM_CH-1:0]        res_ready_o,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [DATA_W-1:0]        io_out_o,
  output logic                     irq_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW = DATA_W + 3;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              ovf, udf, irq_en, gpio_sel;
  logic [CW-1:0]     rr_ptr, gnt_id, rr_next;
  logic              gnt_found;
  logic              empty, full, acc, rd, wr, pop, clr, push;
  logic [7:0]        off;
  logic [31:0]       rdata;
  logic [EW-1:0]     head;
  logic [DATA_W-1:0] push_data;
  logic              unused;

  assign unused = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_dat_i[31:3], BASE};

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];
  assign off   = wbs_adr_i[7:0];
  assign acc   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign rd    = acc & ~wbs_we_i;
  assign wr    = acc & wbs_we_i;
  assign pop   = rd & (off == 8'h00) & ~empty;
  assign clr   = wr & (off == 8'h0C) & wbs_dat_i[2];

  // First valid channel at or after rr_ptr, scanning with modulo wrap.
  always_comb begin
    logic [CW:0] idx;
    idx       = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (!gnt_found && res_valid_i[idx[CW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[CW-1:0];
      end
    end
  end

  // A clear in the same cycle suppresses the grant so the producer keeps its word.
  assign push        = gnt_found & ~full & ~clr;
  assign res_ready_o = push ? (NUM_CH'(1) << gnt_id) : '0;
  assign push_data   = res_data_i[gnt_id*DATA_W +: DATA_W];
  assign rr_next     = (gnt_id == CW'(NUM_CH-1)) ? '0 : gnt_id + CW'(1);

  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata = empty ? '0 : 32'(head[DATA_W-1:0]);
      8'h04:   rdata = empty ? '0 : {29'b0, head[EW-1 -: 3]};
      8'h08:   rdata = {16'b0, 8'(count), 4'b0, udf, ovf, full, empty};
      8'h0C:   rdata = {30'b0, gpio_sel, irq_en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {3'(gnt_id), push_data};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      irq_en    <= 1'b0;
      gpio_sel  <= 1'b0;
      rr_ptr    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      io_out_o  <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      if (rd)       wbs_dat_o <= rdata;
      else if (acc) wbs_dat_o <= '0;
      if (wr && off == 8'h0C) {gpio_sel, irq_en} <= wbs_dat_i[1:0];
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: ;
        endcase
        if (|res_valid_i && full)            ovf <= 1'b1;
        if (rd && off == 8'h00 && empty)     udf <= 1'b1;
      end
      if (push) rr_ptr <= rr_next;
      if (gpio_sel)  io_out_o <= empty ? '0 : head[DATA_W-1:0];
      else if (push) io_out_o <= push_data;
      irq_o <= irq_en & ~empty;
    end
  end
endmodule

// File: tb/tb_fpu_result_bridge.sv
// Scenario tasks plus a randomized run scored against a queue model of the bridge.
module tb_fpu_result_bridge;
  localparam int DW = 32, DEPTH = 8, NCH = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk = 1'b0, rst;
  logic [NCH-1:0]    valid, ready;
  logic [NCH*DW-1:0] data;
  logic              stb, cyc, we, ack, irq;
  logic [3:0]        sel;
  logic [31:0]       wdat, adr, rdat;
  logic [DW-1:0]     io;
  logic [DW-1:0]     hold [NCH];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  fpu_result_bridge #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .res_valid_i(valid), .res_data_i(data),
    .res_ready_o(ready), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack),
    .wbs_dat_o(rdat), .io_out_o(io), .irq_o(irq));

  function automatic int pick(input logic [NCH-1:0] v, input int r);
    for (int k = 0; k < NCH; k++) if (v[(r + k) % NCH]) return (r + k) % NCH;
    return -1;
  endfunction

  task automatic drive(input logic [NCH-1:0] v);
    valid = v;
    for (int c = 0; c < NCH; c++) data[c*DW +: DW] = hold[c];
  endtask

  task automatic apply_reset();
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; wdat = '0; adr = BASE;
    for (int c = 0; c < NCH; c++) hold[c] = '0;
    drive('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One Wishbone access; ok reports ack high exactly one cycle later and low after.
  task automatic wb_access(input logic w, input logic [7:0] off, input logic [31:0] wd,
                           output logic [31:0] r, output logic ok);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | 32'(off); wdat = wd;
    @(posedge clk); @(negedge clk);
    ok = (ack === 1'b1);
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    ok = ok & (ack === 1'b0);
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] r, output logic ok);
    wb_access(1'b0, off, '0, r, ok);
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] wd, output logic ok);
    logic [31:0] d;
    wb_access(1'b1, off, wd, d, ok);
  endtask

  task automatic test_reset();
    logic [31:0] r; logic ok;
    apply_reset();
    checks++; if ({ack, rdat, io, irq} !== '0)
      $display("FAIL reset_outputs: ack=%b dat=%h io=%h irq=%b, want all 0", ack, rdat, io, irq);
    else passed++;
    drive(2'b11); #1;
    checks++; if (ready !== 2'b01) $display("FAIL reset_rr_ptr: ready=%b want 01", ready); else passed++;
    drive('0);
    wb_rd(8'h08, r, ok);
    checks++; if (!ok || r !== 32'h1) $display("FAIL reset_status: ok=%b got %h want 00000001", ok, r);
    else passed++;
  endtask

  task automatic test_single_push();
    logic [31:0] r; logic ok;
    apply_reset();
    wb_wr(8'h0C, 32'h1, ok);
    hold[0] = 32'h3F80_0000; drive(2'b01); #1;
    checks++; if (ready !== 2'b01) $display("FAIL single_ready: got %b want 01", ready); else passed++;
    @(posedge clk); @(negedge clk); drive('0);
    checks++; if (io !== 32'h3F80_0000) $display("FAIL single_gpio: got %h want 3f800000", io); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if (irq !== 1'b1) $display("FAIL single_irq_rise: got %b want 1", irq); else passed++;
    wb_rd(8'h00, r, ok);
    checks++; if (!ok || r !== 32'h3F80_0000) $display("FAIL single_read: ok=%b got %h want 3f800000", ok, r);
    else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL single_irq_fall: got %b want 0", irq); else passed++;
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h1) $display("FAIL single_status: got %h want 00000001", r); else passed++;
  endtask

  task automatic test_round_robin();
    logic [31:0] r; logic ok; logic [NCH-1:0] want; int rr, g;
    logic [31:0] exp_d [4] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    apply_reset();
    rr = 0; hold[0] = 32'hA0; hold[1] = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11); #1;
      g = pick(2'b11, rr);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (ready !== want || g != k % 2)
        $display("FAIL rr_grant%0d: got %b want %b", k, ready, want);
      else passed++;
      @(posedge clk);
      hold[g] = hold[g] + 1; rr = (g + 1) % NCH;
      @(negedge clk);
    end
    drive('0);
    for (int k = 0; k < 4; k++) begin
      wb_rd(8'h04, r, ok);
      checks++; if (r !== 32'(k % 2)) $display("FAIL rr_headch%0d: got %0d want %0d", k, r, k % 2); else passed++;
      wb_rd(8'h00, r, ok);
      checks++; if (r !== exp_d[k]) $display("FAIL rr_data%0d: got %h want %h", k, r, exp_d[k]); else passed++;
    end
  endtask

  task automatic test_full_ovf();
    logic [31:0] r; logic ok;
    apply_reset();
    hold[0] = 32'hC000_0000;
    for (int k = 0; k < DEPTH; k++) begin
      drive(2'b01); @(posedge clk); hold[0] = hold[0] + 1; @(negedge clk);
    end
    drive(2'b01); #1;
    checks++; if (ready !== 2'b00) $display("FAIL full_ready: got %b want 00", ready); else passed++;
    @(posedge clk); @(negedge clk);
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h0000_0806) $display("FAIL full_status: got %h want 00000806", r); else passed++;
    wb_rd(8'h00, r, ok);
    checks++; if (r !== 32'hC000_0000) $display("FAIL full_pop: got %h want c0000000", r); else passed++;
    drive('0);
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h0000_0806) $display("FAIL full_refill: got %h want 00000806", r); else passed++;
    for (int k = 1; k <= DEPTH; k++) begin
      wb_rd(8'h00, r, ok);
      checks++; if (r !== 32'hC000_0000 + 32'(k))
        $display("FAIL full_drain%0d: got %h want %h", k, r, 32'hC000_0000 + 32'(k));
      else passed++;
    end
  endtask

  task automatic test_underflow();
    logic [31:0] r; logic ok;
    apply_reset();
    wb_rd(8'h00, r, ok);
    checks++; if (!ok || r !== 32'h0) $display("FAIL udf_read: ok=%b got %h want 0", ok, r); else passed++;
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h9) $display("FAIL udf_status: got %h want 00000009", r); else passed++;
    wb_wr(8'h0C, 32'h4, ok);
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h1) $display("FAIL udf_clear: got %h want 00000001", r); else passed++;
    wb_rd(8'h0C, r, ok);
    checks++; if (r !== 32'h0) $display("FAIL ctrl_selfclear: got %h want 0", r); else passed++;
    wb_rd(8'h40, r, ok);
    checks++; if (!ok || r !== 32'h0) $display("FAIL unmapped_read: ok=%b got %h want 0", ok, r); else passed++;
  endtask

  task automatic test_full_pop_push();
    logic [31:0] r; logic ok;
    apply_reset();
    hold[0] = 32'hD0; hold[1] = 32'hE0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(2'b01); @(posedge clk); hold[0] = hold[0] + 1; @(negedge clk);
    end
    drive(2'b10); #1;
    checks++; if (ready !== 2'b00) $display("FAIL fpp_ready_full: got %b want 00", ready); else passed++;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
    @(posedge clk); @(negedge clk);
    checks++; if (ack !== 1'b1 || rdat !== 32'hD0) $display("FAIL fpp_pop: ack=%b dat=%h want 1/d0", ack, rdat);
    else passed++;
    checks++; if (ready !== 2'b10) $display("FAIL fpp_ready_after_pop: got %b want 10", ready); else passed++;
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (ready !== 2'b00) $display("FAIL fpp_ready_refull: got %b want 00", ready); else passed++;
    drive('0);
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h0000_0806) $display("FAIL fpp_status: got %h want 00000806", r); else passed++;
    for (int k = 0; k < DEPTH - 1; k++) wb_rd(8'h00, r, ok);
    checks++; if (r !== 32'hD7) $display("FAIL fpp_last_ch0: got %h want d7", r); else passed++;
    wb_rd(8'h04, r, ok);
    checks++; if (r !== 32'h1) $display("FAIL fpp_headch: got %h want 1", r); else passed++;
    wb_rd(8'h00, r, ok);
    checks++; if (r !== 32'hE0) $display("FAIL fpp_ch1_word: got %h want e0", r); else passed++;
  endtask

  task automatic test_gpio_head();
    logic [31:0] r; logic ok;
    apply_reset();
    wb_wr(8'h0C, 32'h2, ok);
    hold[0] = 32'h11; hold[1] = 32'h22;
    drive(2'b01); @(posedge clk); @(negedge clk);
    drive(2'b10); @(posedge clk); @(negedge clk);
    drive('0); @(posedge clk); @(negedge clk);
    checks++; if (io !== 32'h11) $display("FAIL gpio_head0: got %h want 11", io); else passed++;
    wb_rd(8'h00, r, ok);
    checks++; if (io !== 32'h22) $display("FAIL gpio_head1: got %h want 22", io); else passed++;
    wb_rd(8'h00, r, ok);
    checks++; if (io !== 32'h0) $display("FAIL gpio_head_empty: got %h want 0", io); else passed++;
  endtask

  task automatic test_reset_midack();
    logic [31:0] r; logic ok;
    apply_reset();
    wb_wr(8'h0C, 32'h1, ok);
    hold[0] = 32'hF0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b01); @(posedge clk); hold[0] = hold[0] + 1; @(negedge clk);
    end
    drive('0); @(posedge clk); @(negedge clk);
    checks++; if (irq !== 1'b1 || io !== 32'hF2) $display("FAIL midack_pre: irq=%b io=%h want 1/f2", irq, io);
    else passed++;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h08;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({ack, io, irq} !== '0) $display("FAIL midack_reset: ack=%b io=%h irq=%b want 0", ack, io, irq);
    else passed++;
    rst = 1'b0;
    wb_rd(8'h08, r, ok);
    checks++; if (r !== 32'h1) $display("FAIL midack_status: got %h want 00000001", r); else passed++;
    wb_rd(8'h0C, r, ok);
    checks++; if (r !== 32'h0) $display("FAIL midack_ctrl: got %h want 0", r); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] q_dat [$];
    logic [31:0] r, want_r, last;
    logic [NCH-1:0] v, want;
    logic ok, m_ovf, m_udf;
    int rr, g;
    apply_reset();
    rr = 0; m_ovf = 1'b0; m_udf = 1'b0;
    for (int c = 0; c < NCH; c++) hold[c] = $urandom;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 7) begin
        v = NCH'($urandom_range(0, (1 << NCH) - 1));
        drive(v); #1;
        g = -1; want = '0;
        if (v != '0 && q_dat.size() < DEPTH) begin g = pick(v, rr); want = NCH'(1 << g); end
        if (v != '0 && q_dat.size() == DEPTH) m_ovf = 1'b1;
        checks++; if (ready !== want) $display("FAIL rand_ready%0d: got %b want %b", it, ready, want);
        else passed++;
        @(posedge clk);
        last = '0;
        if (g >= 0) begin
          q_dat.push_back(hold[g]); last = hold[g];
          rr = (g + 1) % NCH; hold[g] = $urandom;
        end
        @(negedge clk);
        if (g >= 0) begin
          checks++; if (io !== last) $display("FAIL rand_gpio%0d: got %h want %h", it, io, last);
          else passed++;
        end
      end else begin
        drive('0);
        if (q_dat.size() == 0) begin want_r = '0; m_udf = 1'b1; end
        else want_r = q_dat.pop_front();
        wb_rd(8'h00, r, ok);
        checks++; if (!ok || r !== want_r) $display("FAIL rand_read%0d: ok=%b got %h want %h", it, ok, r, want_r);
        else passed++;
      end
    end
    drive('0);
    want_r = {16'b0, 8'(q_dat.size()), 4'b0, m_udf, m_ovf, q_dat.size() == DEPTH, q_dat.size() == 0};
    wb_rd(8'h08, r, ok);
    checks++; if (r !== want_r) $display("FAIL rand_status: got %h want %h", r, want_r); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_full_ovf();
    test_underflow();
    test_full_pop_push();
    test_gpio_head();
    test_reset_midack();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
